// File: rtl/vadd_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vadd_req_sequencer
// Brief    : Turns a vector-add style command into a stream of per-beat ALU
//            requests (address, byte enables, mask start index, first/last
//            flags) and tracks outstanding ALU results before reporting done.
// Revision : 1.0 - initial release
// ============================================================================
module vadd_req_sequencer #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int VL_WIDTH      = 11,
    parameter bit ENABLE_64_BIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    // command channel
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [VL_WIDTH-1:0]     cmd_vl_i,
    input  logic [1:0]              cmd_sew_i,
    input  logic [8:0]              cmd_opsel_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst_i,
    // operand channel
    input  logic                    opnd_valid_i,
    output logic                    opnd_ready_o,
    input  logic [DATA_WIDTH-1:0]   opnd_vec0_i,
    input  logic [DATA_WIDTH-1:0]   opnd_vec1_i,
    // ALU request
    output logic                    alu_valid_o,
    output logic [DATA_WIDTH-1:0]   alu_vec0_o,
    output logic [DATA_WIDTH-1:0]   alu_vec1_o,
    output logic [1:0]              alu_sew_o,
    output logic [8:0]              alu_opsel_o,
    output logic [ADDR_WIDTH-1:0]   alu_addr_o,
    output logic [DATA_WIDTH/8-1:0] alu_be_o,
    output logic [5:0]              alu_start_idx_o,
    output logic                    alu_req_start_o,
    output logic                    alu_req_end_o,
    // ALU result strobe
    input  logic                    alu_out_valid_i,
    // status
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int c_NB       = DATA_WIDTH / 8;
    localparam int c_IDX_W    = VL_WIDTH + 1;      // one spare bit so idx+EPB never wraps
    localparam int c_DW_SHIFT = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    // latched command
    logic [VL_WIDTH-1:0]   vl_q;
    logic [1:0]            sew_q;
    logic [8:0]            opsel_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [c_IDX_W-1:0]    elem_idx_q;
    logic [VL_WIDTH-1:0]   beat_idx_q;

    // in-flight tracking and sticky error
    logic [3:0]            inflight_q;
    logic                  err_q;

    // registered ALU request
    logic                  alu_valid_q;
    logic [DATA_WIDTH-1:0] alu_vec0_q;
    logic [DATA_WIDTH-1:0] alu_vec1_q;
    logic [1:0]            alu_sew_q;
    logic [8:0]            alu_opsel_q;
    logic [ADDR_WIDTH-1:0] alu_addr_q;
    logic [c_NB-1:0]       alu_be_q;
    logic [5:0]            alu_start_idx_q;
    logic                  alu_req_start_q;
    logic                  alu_req_end_q;

    logic                  w_cmd_fire;
    logic                  w_sew_bad;
    logic                  w_cmd_empty;
    logic                  w_opnd_fire;
    logic [c_IDX_W-1:0]    w_epb;
    logic [c_IDX_W-1:0]    w_elem_next;
    logic                  w_last;
    logic [c_IDX_W-1:0]    w_rem;
    logic [c_IDX_W-1:0]    w_bytes;
    logic [c_NB-1:0]       w_be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_drain_exit;

    // A 64-bit element is only legal when enabled and the datapath can hold it.
    assign w_sew_bad   = (cmd_sew_i == 2'b11) && (!ENABLE_64_BIT || (DATA_WIDTH < 64));
    assign w_cmd_empty = (cmd_vl_i == '0) || w_sew_bad;
    assign w_cmd_fire  = cmd_ready_o && cmd_valid_i;
    assign w_opnd_fire = opnd_ready_o && opnd_valid_i;

    assign w_epb       = c_IDX_W'(c_NB) >> sew_q;
    assign w_elem_next = elem_idx_q + w_epb;
    assign w_last      = (w_elem_next >= {1'b0, vl_q});
    assign w_rem       = {1'b0, vl_q} - elem_idx_q;
    assign w_bytes     = w_rem << sew_q;

    // Mask ops address by bit position; others by beat number.
    assign w_addr = opsel_q[8] ? (dst_q + ADDR_WIDTH'(elem_idx_q >> c_DW_SHIFT))
                               : (dst_q + ADDR_WIDTH'(beat_idx_q));

    // A request still sitting on the ALU port has not been counted yet.
    assign w_drain_exit = (state_q == S_DRAIN) && (inflight_q == 4'd0) && !alu_valid_q;

    // Byte enables: full except on the last beat, which covers the remaining bytes.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < c_NB; b++) begin
            w_be[b] = !w_last || (w_bytes > c_IDX_W'(b));
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_d      = state_q;
        cmd_ready_o  = 1'b0;
        opnd_ready_o = 1'b0;
        busy_o       = (state_q != S_IDLE);
        done_o       = w_drain_exit && !rst;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = w_cmd_empty ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                opnd_ready_o = 1'b1;
                if (opnd_valid_i && w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_exit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and per-beat element/beat progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            vl_q       <= '0;
            sew_q      <= '0;
            opsel_q    <= '0;
            dst_q      <= '0;
            elem_idx_q <= '0;
            beat_idx_q <= '0;
        end else if (w_cmd_fire) begin
            vl_q       <= cmd_vl_i;
            sew_q      <= cmd_sew_i;
            opsel_q    <= cmd_opsel_i;
            dst_q      <= cmd_dst_i;
            elem_idx_q <= '0;
            beat_idx_q <= '0;
        end else if (w_opnd_fire) begin
            elem_idx_q <= w_elem_next;
            beat_idx_q <= beat_idx_q + VL_WIDTH'(1);
        end
    end

    // ALU request register: one pulse per operand handshake, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !w_opnd_fire) begin
            alu_valid_q     <= 1'b0;
            alu_vec0_q      <= '0;
            alu_vec1_q      <= '0;
            alu_sew_q       <= '0;
            alu_opsel_q     <= '0;
            alu_addr_q      <= '0;
            alu_be_q        <= '0;
            alu_start_idx_q <= '0;
            alu_req_start_q <= 1'b0;
            alu_req_end_q   <= 1'b0;
        end else begin
            alu_valid_q     <= 1'b1;
            alu_vec0_q      <= opnd_vec0_i;
            alu_vec1_q      <= opnd_vec1_i;
            alu_sew_q       <= sew_q;
            alu_opsel_q     <= opsel_q;
            alu_addr_q      <= w_addr;
            alu_be_q        <= w_be;
            alu_start_idx_q <= opsel_q[8] ? elem_idx_q[5:0] : 6'd0;
            alu_req_start_q <= (beat_idx_q == '0);
            alu_req_end_q   <= w_last;
        end
    end

    // Outstanding-result counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            case ({alu_valid_q, alu_out_valid_i})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   if (inflight_q != 4'd0) inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
            if ((w_cmd_fire && w_sew_bad) || (alu_out_valid_i && (inflight_q == 4'd0))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o           = err_q;
    assign alu_valid_o     = alu_valid_q;
    assign alu_vec0_o      = alu_vec0_q;
    assign alu_vec1_o      = alu_vec1_q;
    assign alu_sew_o       = alu_sew_q;
    assign alu_opsel_o     = alu_opsel_q;
    assign alu_addr_o      = alu_addr_q;
    assign alu_be_o        = alu_be_q;
    assign alu_start_idx_o = alu_start_idx_q;
    assign alu_req_start_o = alu_req_start_q;
    assign alu_req_end_o   = alu_req_end_q;

endmodule
`default_nettype wire

// File: tb/tb_vadd_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vadd_req_sequencer
// Brief    : Directed bench for vadd_req_sequencer (64-bit datapath) with a
//            per-beat reference model and a fixed-latency ALU responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vadd_req_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [10:0] cmd_vl_i = '0;
    logic [1:0]  cmd_sew_i = '0;
    logic [8:0]  cmd_opsel_i = '0;
    logic [31:0] cmd_dst_i = '0;
    logic        opnd_valid_i = 1'b0;
    logic        opnd_ready_o;
    logic [63:0] opnd_vec0_i = '0;
    logic [63:0] opnd_vec1_i = '0;
    logic        alu_valid_o;
    logic [63:0] alu_vec0_o;
    logic [63:0] alu_vec1_o;
    logic [1:0]  alu_sew_o;
    logic [8:0]  alu_opsel_o;
    logic [31:0] alu_addr_o;
    logic [7:0]  alu_be_o;
    logic [5:0]  alu_start_idx_o;
    logic        alu_req_start_o;
    logic        alu_req_end_o;
    logic        alu_out_valid_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    vadd_req_sequencer #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(11), .ENABLE_64_BIT(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_vl_i(cmd_vl_i), .cmd_sew_i(cmd_sew_i), .cmd_opsel_i(cmd_opsel_i), .cmd_dst_i(cmd_dst_i),
        .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o),
        .opnd_vec0_i(opnd_vec0_i), .opnd_vec1_i(opnd_vec1_i),
        .alu_valid_o(alu_valid_o), .alu_vec0_o(alu_vec0_o), .alu_vec1_o(alu_vec1_o),
        .alu_sew_o(alu_sew_o), .alu_opsel_o(alu_opsel_o), .alu_addr_o(alu_addr_o),
        .alu_be_o(alu_be_o), .alu_start_idx_o(alu_start_idx_o),
        .alu_req_start_o(alu_req_start_o), .alu_req_end_o(alu_req_end_o),
        .alu_out_valid_i(alu_out_valid_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [1:0]  sew;
        logic [8:0]  op;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [5:0]  sidx;
        logic        st;
        logic        en;
    } beat_t;

    beat_t exp_q[$];
    beat_t cap_q[$];
    beat_t act_b, exp_b;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_aov_cyc = -1;
    bit    en_cmp = 1'b0;
    bit    alu_flush = 1'b0;
    int    lat = 6;
    logic [15:0] sh = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] opnd0(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k + 1);
    endfunction

    function automatic logic [63:0] opnd1(input int k);
        return 64'hDEAD_BEEF_0000_0000 + 64'(k * 3);
    endfunction

    // Reference: enumerate the beats a command must produce, element by element.
    task automatic model_cmd(input int vl, input int sew, input logic [8:0] op,
                             input logic [31:0] dst, output int nb);
        beat_t b;
        int    epb;
        int    bytes;
        nb = 0;
        if (vl == 0 || sew == 3) return;
        epb = 8 / (1 << sew);
        for (int e = 0; e < vl; e += epb) begin
            bytes  = (vl - e) * (1 << sew);
            b.v0   = opnd0(nb);
            b.v1   = opnd1(nb);
            b.sew  = 2'(sew);
            b.op   = op;
            b.addr = op[8] ? dst + 32'(e / 64) : dst + 32'(nb);
            b.sidx = op[8] ? 6'(e % 64) : 6'd0;
            b.en   = (e + epb >= vl);
            b.be   = (!b.en || bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
            b.st   = (nb == 0);
            exp_q.push_back(b);
            nb++;
        end
    endtask

    // ALU stand-in: one result strobe per request, lat cycles later.
    always @(negedge clk) begin
        if (alu_flush) sh = '0;
        else           sh = {sh[14:0], alu_valid_o};
        alu_out_valid_i = sh[lat];
        if (sh[lat]) last_aov_cyc = cyc;
    end

    // Every cycle: an issued beat must match the model, an idle port must be all zero.
    always @(negedge clk) begin
        if (en_cmp) begin
            act_b = {alu_vec0_o, alu_vec1_o, alu_sew_o, alu_opsel_o, alu_addr_o,
                     alu_be_o, alu_start_idx_o, alu_req_start_o, alu_req_end_o};
            if (alu_valid_o) begin
                cap_q.push_back(act_b);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 256'(act_b), 256'(0));
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("beat", 256'(act_b), 256'(exp_b));
                end
            end else begin
                chk("idle_alu_fields_zero", 256'(act_b), 256'(0));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        alu_flush = 1'b1;
        cmd_valid_i = 1'b0;
        opnd_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        alu_flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_cmd(input int vl, input int sew, input logic [8:0] op,
                            input logic [31:0] dst, output int nb, output int acc_cyc);
        int t = 0;
        cap_q.delete();
        model_cmd(vl, sew, op, dst, nb);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_vl_i    = 11'(vl);
        cmd_sew_i   = 2'(sew);
        cmd_opsel_i = op;
        cmd_dst_i   = dst;
        @(negedge clk);
        while (!cmd_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accepted", 256'(cmd_ready_o), 256'(1));
        acc_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        cmd_vl_i    = 11'($urandom);
        cmd_sew_i   = 2'($urandom);
        cmd_opsel_i = 9'($urandom);
        cmd_dst_i   = $urandom;
    endtask

    task automatic drive_beats(input int n, input bit rnd);
        int k = 0;
        int t = 0;
        while (k < n && t < 400) begin
            @(posedge clk); #1;
            opnd_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            opnd_vec0_i  = opnd_valid_i ? opnd0(k) : {$urandom, $urandom};
            opnd_vec1_i  = opnd_valid_i ? opnd1(k) : {$urandom, $urandom};
            @(negedge clk);
            if (opnd_valid_i && opnd_ready_o) k++;
            t++;
        end
        @(posedge clk); #1;
        opnd_valid_i = 1'b0;
        chk("beats_handshaken", 256'(k), 256'(n));
    endtask

    task automatic wait_done(output int done_cyc);
        int t = 0;
        @(negedge clk);
        while (!done_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 256'(done_o), 256'(1));
        chk("busy_in_done_cycle", 256'(busy_o), 256'(1));
        done_cyc = cyc;
        @(negedge clk);
        chk("done_one_cycle", 256'(done_o), 256'(0));
        chk("idle_after_done", 256'({busy_o, cmd_ready_o}), 256'(2'b01));
    endtask

    initial begin
        int nb, acc, dc, nd;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        en_cmp = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 256'(cmd_ready_o), 256'(1));
        chk("reset_status", 256'({busy_o, done_o, err_o, opnd_ready_o, alu_valid_o}), 256'(0));

        // operands offered while idle must be ignored
        cap_q.delete();
        @(posedge clk); #1;
        opnd_valid_i = 1'b1;
        opnd_vec0_i  = 64'h1234;
        repeat (4) @(posedge clk);
        #1;
        opnd_valid_i = 1'b0;
        @(negedge clk);
        chk("idle_opnd_ignored", 256'(cap_q.size()), 256'(0));

        // sew=0, vl=20, dst=0x100, plain op
        send_cmd(20, 0, 9'h005, 32'h100, nb, acc);
        chk("busy_after_accept", 256'(busy_o), 256'(1));
        drive_beats(nb, 1'b0);
        wait_done(dc);
        chk("done_after_last_result", 256'(dc), 256'(last_aov_cyc + 1));
        chk("nbeats_vl20", 256'(cap_q.size()), 256'(3));
        chk("addr_b0", 256'(cap_q[0].addr), 256'(32'h100));
        chk("addr_b1", 256'(cap_q[1].addr), 256'(32'h101));
        chk("addr_b2", 256'(cap_q[2].addr), 256'(32'h102));
        chk("be_beats", 256'({cap_q[0].be, cap_q[1].be, cap_q[2].be}), 256'(24'hFF_FF_0F));
        chk("start_end_flags", 256'({cap_q[0].st, cap_q[0].en, cap_q[1].st, cap_q[1].en,
                                     cap_q[2].st, cap_q[2].en}), 256'(6'b10_00_01));
        chk("model_drained", 256'(exp_q.size()), 256'(0));

        // sew=1, vl=5 -> two beats
        send_cmd(5, 1, 9'h011, 32'h200, nb, acc);
        drive_beats(nb, 1'b0);
        wait_done(dc);
        chk("sew1_vl5_beats", 256'(cap_q.size()), 256'(2));
        chk("sew1_vl5_be", 256'({cap_q[0].be, cap_q[1].be}), 256'(16'hFF_03));

        // sew=1, vl=4 -> single beat
        send_cmd(4, 1, 9'h022, 32'h300, nb, acc);
        drive_beats(nb, 1'b0);
        wait_done(dc);
        chk("sew1_vl4_beats", 256'(cap_q.size()), 256'(1));
        chk("single_beat_flags_be", 256'({cap_q[0].st, cap_q[0].en, cap_q[0].be}),
            256'({2'b11, 8'hFF}));

        // mask op, sew=0, vl=20, dst=0x40
        send_cmd(20, 0, 9'h103, 32'h40, nb, acc);
        drive_beats(nb, 1'b0);
        wait_done(dc);
        chk("mask_start_idx", 256'({cap_q[0].sidx, cap_q[1].sidx, cap_q[2].sidx}),
            256'({6'd0, 6'd8, 6'd16}));
        chk("mask_addr", 256'({cap_q[0].addr, cap_q[1].addr, cap_q[2].addr}),
            256'({32'h40, 32'h40, 32'h40}));

        // vl=0 -> no beats, done the cycle after accept
        send_cmd(0, 0, 9'h001, 32'h10, nb, acc);
        wait_done(dc);
        chk("vl0_done_cycle", 256'(dc), 256'(acc + 1));
        chk("vl0_no_beats", 256'(cap_q.size()), 256'(0));
        chk("vl0_no_err", 256'(err_o), 256'(0));

        // sew=3 not enabled -> no beats, done, sticky err
        send_cmd(8, 3, 9'h001, 32'h10, nb, acc);
        wait_done(dc);
        chk("sew3_done_cycle", 256'(dc), 256'(acc + 1));
        chk("sew3_no_beats", 256'(cap_q.size()), 256'(0));
        chk("sew3_err", 256'(err_o), 256'(1));
        repeat (3) @(negedge clk);
        chk("err_sticky", 256'(err_o), 256'(1));
        do_reset();
        @(negedge clk);
        chk("err_cleared_by_reset", 256'(err_o), 256'(0));

        // long command with random operand valid and 6-cycle ALU latency
        send_cmd(203, 0, 9'h0AA, 32'h1000, nb, acc);
        drive_beats(nb, 1'b1);
        wait_done(dc);
        chk("random_beats", 256'(cap_q.size()), 256'(26));
        chk("random_done_after_result", 256'(dc), 256'(last_aov_cyc + 1));
        chk("random_no_err", 256'(err_o), 256'(0));

        // reset while issuing: abandon the command, no done
        send_cmd(100, 0, 9'h005, 32'h500, nb, acc);
        drive_beats(3, 1'b0);
        do_reset();
        @(negedge clk);
        chk("rst_issue_idle", 256'({cmd_ready_o, busy_o, done_o, alu_valid_o}), 256'(4'b1000));
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        chk("rst_issue_no_done", 256'(nd), 256'(0));
        chk("rst_issue_no_err", 256'(err_o), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
